// File: rtl/mac_rx_packet_fifo.sv
// Receive packet FIFO between an AXI-stream MAC and the NIC read pipe.
// Entries become readable only once a frame ends with a good FCS.
module mac_rx_packet_fifo #(
  parameter int MAC_WIDTH   = 64,
  parameter int TKEEP_WIDTH = MAC_WIDTH / 8,
  parameter int DEPTH_LOG2  = 9,
  parameter int CNT_WIDTH   = 16,
  localparam int NIC_WIDTH  = MAC_WIDTH + TKEEP_WIDTH + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   rx_axis_resetn,
  input  logic [MAC_WIDTH-1:0]   rx_axis_tdata,
  input  logic [TKEEP_WIDTH-1:0] rx_axis_tkeep,
  input  logic                   rx_axis_tvalid,
  input  logic                   rx_axis_tlast,
  input  logic                   rx_axis_tuser,
  output logic                   rx_axis_tready,
  output logic [NIC_WIDTH-1:0]   RX_FIFO_pipe_read_data,
  input  logic                   RX_FIFO_pipe_read_req,
  output logic                   RX_FIFO_pipe_read_ack,
  output logic [DEPTH_LOG2:0]    fifo_level,
  output logic [CNT_WIDTH-1:0]   good_frame_count,
  output logic [CNT_WIDTH-1:0]   bad_fcs_count,
  output logic [CNT_WIDTH-1:0]   overflow_drop_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, WRITE, DROP} wr_state_t;

  wr_state_t state_reg, state_next;

  logic [NIC_WIDTH-1:0] mem [DEPTH];

  logic [DEPTH_LOG2:0] wr_ptr_reg, wr_ptr_next;
  logic [DEPTH_LOG2:0] commit_ptr_reg, commit_ptr_next;
  logic [DEPTH_LOG2:0] rd_ptr_reg;
  logic                resetn_reg;
  logic                beat, full, wr_en, read_fire;
  logic [2:0]          cnt_inc;
  logic [CNT_WIDTH-1:0] cnt_reg [3];

  assign rx_axis_tready         = ~reset;
  assign rx_axis_resetn         = resetn_reg;
  assign beat                   = rx_axis_tvalid & rx_axis_tready;
  assign fifo_level             = wr_ptr_reg - rd_ptr_reg;
  assign full                   = (fifo_level == FULL_LEVEL);
  assign RX_FIFO_pipe_read_ack  = (rd_ptr_reg != commit_ptr_reg);
  assign RX_FIFO_pipe_read_data = mem[rd_ptr_reg[DEPTH_LOG2-1:0]];
  assign read_fire              = RX_FIFO_pipe_read_req & RX_FIFO_pipe_read_ack;

  // cnt_inc: [0] good frame, [1] bad FCS, [2] overflow drop
  always_comb begin
    state_next      = state_reg;
    wr_ptr_next     = wr_ptr_reg;
    commit_ptr_next = commit_ptr_reg;
    wr_en           = 1'b0;
    cnt_inc         = 3'b000;
    if (beat) begin
      case (state_reg)
        IDLE, WRITE: begin
          if (rx_axis_tlast && !rx_axis_tuser) begin
            wr_ptr_next = commit_ptr_reg;
            cnt_inc[1]  = 1'b1;
            state_next  = IDLE;
          end else if (full) begin
            wr_ptr_next = commit_ptr_reg;
            if (rx_axis_tlast) begin
              cnt_inc[2] = 1'b1;
              state_next = IDLE;
            end else begin
              state_next = DROP;
            end
          end else begin
            wr_en       = 1'b1;
            wr_ptr_next = wr_ptr_reg + 1'b1;
            if (rx_axis_tlast) begin
              commit_ptr_next = wr_ptr_reg + 1'b1;
              cnt_inc[0]      = 1'b1;
              state_next      = IDLE;
            end else begin
              state_next = WRITE;
            end
          end
        end
        DROP: begin
          if (rx_axis_tlast) begin
            cnt_inc[2] = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    resetn_reg <= ~reset;
    if (reset) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      commit_ptr_reg <= '0;
      rd_ptr_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      wr_ptr_reg     <= wr_ptr_next;
      commit_ptr_reg <= commit_ptr_next;
      if (read_fire) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  // Storage is never reset so it can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= {rx_axis_tlast, rx_axis_tdata, rx_axis_tkeep};
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_WIDTH{1'b1}})) begin
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign good_frame_count    = cnt_reg[0];
  assign bad_fcs_count       = cnt_reg[1];
  assign overflow_drop_count = cnt_reg[2];

endmodule
